// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter that sequences NREQ requesters onto one APB slave.
// Optional ACCESS-phase timeout abort is enabled with `define APB_TIMEOUT_EN.
module apb_rr_master #(
    parameter int NREQ    = 4,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DWIDTH-1:0]        req_rdata,
    output logic                     err,
    output logic                     p_sel,
    output logic                     p_en,
    output logic                     p_write,
    output logic [AWIDTH-1:0]        addr,
    output logic [DWIDTH-1:0]        wdata,
    input  logic [DWIDTH-1:0]        rdata,
    input  logic                     p_ready
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick;
    logic            found;
    logic [NREQ-1:0] elig;
    int              j;

    // The requester completing this cycle is still holding req; keep it out of the search.
    assign elig = req & ~done;

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && elig[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          expire;
    assign expire = !p_ready && (cnt == CW'(TIMEOUT - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            done      <= '0;
            req_rdata <= '0;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            p_write   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
`ifdef APB_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done <= '0;
`ifdef APB_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: if (found) begin
                    p_write <= req_write[pick];
                    addr    <= req_addr[int'(pick)*AWIDTH +: AWIDTH];
                    wdata   <= req_wdata[int'(pick)*DWIDTH +: DWIDTH];
                    gnt     <= NREQ'(1) << pick;
                    ptr     <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    p_sel   <= 1'b1;
                    state   <= SETUP;
`ifdef APB_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end
                SETUP: begin
                    p_en  <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: if (p_ready) begin
                    if (!p_write) req_rdata <= rdata;
                    done  <= gnt;
                    gnt   <= '0;
                    p_sel <= 1'b0;
                    p_en  <= 1'b0;
                    state <= IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (expire) begin
                    err   <= 1'b1;
                    done  <= gnt;
                    gnt   <= '0;
                    p_sel <= 1'b0;
                    p_en  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed checks of arbitration order, APB phasing, reset and read-back.
// Timeout abort steps run only when APB_TIMEOUT_EN is defined.
module tb_apb_rr_master;
    localparam int NREQ = 4, AW = 8, DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req, req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]  gnt, done;
    logic [DW-1:0]    req_rdata, wdata, rdata;
    logic             err, p_sel, p_en, p_write, p_ready;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    mem [256];
    int               checks = 0, fails = 0;

    always #5 clk = ~clk;

    apb_rr_master #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .req_rdata(req_rdata), .err(err),
        .p_sel(p_sel), .p_en(p_en), .p_write(p_write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .p_ready(p_ready)
    );

    // Minimal APB slave: memory written on a completed write, read combinationally.
    always @(posedge clk)
        if (p_sel && p_en && p_ready && p_write) mem[addr] <= wdata;
    assign rdata = mem[addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n;
        rst = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0; p_ready = 1'b1;
        tick; tick;
        chk("rst_psel", p_sel, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", req_rdata, 0);
        rst = 1'b1;

        // Write to 0x10 by requester 0, three-cycle latency
        set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        req = 4'b0001;
        tick;
        chk("t1_setup_psel", p_sel, 1);
        chk("t1_setup_pen", p_en, 0);
        chk("t1_setup_gnt", gnt, 4'b0001);
        chk("t1_addr", addr, 8'h10);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        chk("t1_pwrite", p_write, 1);
        tick;
        chk("t1_access_pen", p_en, 1);
        chk("t1_access_psel", p_sel, 1);
        tick;
        chk("t1_done", done, 4'b0001);
        chk("t1_err", err, 0);
        chk("t1_gnt_drop", gnt, 0);
        chk("t1_psel_drop", p_sel, 0);
        req = '0;

        // Read back by requester 2
        set_req(2, 1'b0, 8'h10, 32'h0);
        req = 4'b0100;
        tick; chk("t2_gnt_setup", gnt, 4'b0100);
        tick; chk("t2_gnt_access", gnt, 4'b0100);
        tick;
        chk("t2_done", done, 4'b0100);
        chk("t2_rdata", req_rdata, 32'hDEADBEEF);
        req = '0;

        // Round robin from a fresh pointer
        rst = 1'b0; tick; rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h10, 32'h0);
        req = 4'b1111;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick;
            chk("t3_gnt_onehot", {63'b0, $onehot0(gnt)}, 1);
            if (done != '0) begin
                chk($sformatf("t3_order%0d", n), done, 4'b0001 << exp_order[n]);
                chk("t3_rdata", req_rdata, 32'hDEADBEEF);
                n++;
                if (n == 5) req = '0;
            end
        end
        chk("t3_completions", n, 5);

        // Slave wait states: p_ready low for three ACCESS cycles
        set_req(1, 1'b1, 8'h20, 32'h12345678);
        p_ready = 1'b0;
        req = 4'b0010;
        tick;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t4_pen", p_en, 1);
            chk("t4_addr", addr, 8'h20);
            chk("t4_wdata", wdata, 32'h12345678);
            chk("t4_pwrite", p_write, 1);
            chk("t4_no_done", done, 0);
            if (i == 3) p_ready = 1'b1;
        end
        tick;
        chk("t4_done", done, 4'b0010);
        chk("t4_pen_drop", p_en, 0);
        req = '0;

        // Asynchronous reset mid-ACCESS
        set_req(3, 1'b0, 8'h10, 32'h0);
        p_ready = 1'b0;
        req = 4'b1000;
        tick; tick;
        chk("t5_in_access", p_en, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_psel_async", p_sel, 0);
        chk("t5_pen_async", p_en, 0);
        chk("t5_gnt_async", gnt, 0);
        tick;
        chk("t5_no_done", done, 0);
        rst = 1'b1;
        p_ready = 1'b1;
        set_req(1, 1'b1, 8'h30, 32'hCAFEF00D);
        set_req(3, 1'b0, 8'h30, 32'h0);
        req = 4'b1010;
        tick; chk("t5_first_gnt", gnt, 4'b0010);
        tick; tick;
        chk("t5_done1", done, 4'b0010);
        req = 4'b1000;
        tick; chk("t5_second_gnt", gnt, 4'b1000);
        tick; tick;
        chk("t5_done3", done, 4'b1000);
        chk("t5_rdata", req_rdata, 32'hCAFEF00D);
        req = '0;

`ifdef APB_TIMEOUT_EN
        // Timeout abort after 16 ACCESS cycles with p_ready low
        set_req(0, 1'b0, 8'h20, 32'h0);
        p_ready = 1'b0;
        req = 4'b0001;
        tick;
        for (int i = 0; i < 16; i++) begin
            tick;
            chk("t6_waiting", done, 0);
        end
        tick;
        chk("t6_done", done, 4'b0001);
        chk("t6_err", err, 1);
        chk("t6_rdata_kept", req_rdata, 32'hCAFEF00D);
        req = '0;
        p_ready = 1'b1;
        tick;
        chk("t6_err_pulse", err, 0);
        req = 4'b0001;
        tick; tick; tick;
        chk("t6_retry_done", done, 4'b0001);
        chk("t6_retry_err", err, 0);
        chk("t6_retry_rdata", req_rdata, 32'h12345678);
        req = '0;
`endif

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
